id2ex_pipe: RTL and testbench
=============================

Name: id2ex_pipe

Overview:
- ID→EX pipeline register of the 5-stage pipeline. It consumes the stall controls produced by the load-use hazard unit: bubble_id2ex, plus freeze and flush from elsewhere.
- It supplies the EX-side signals the hazard unit checks (EX_dmem_ren, EX_rO), which closes the stall loop.
- It inserts NOPs on bubble or flush and holds state on freeze.
- It tracks a sticky halt state and counts inserted bubbles for performance monitoring.

Parameters:
- DATA_W, 16, datapath width (PC, operands)
- REG_AW, 3, register-index width
- ALUOP_W, 5, ALU opcode width
- CNT_W, 16, bubble-counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- bubble_id2ex  in  1  load-use stall; EX receives a NOP this cycle
- freeze_id2ex  in  1  hold the EX stage (memory-busy stall)
- flush_id2ex  in  1  squash the incoming instruction (branch redirect)
- cnt_clr  in  1  sync clear of bubble_count
- ID_valid  in  1  ID holds a real instruction
- ID_pc  in  DATA_W  instruction PC
- ID_opA, ID_opB  in  DATA_W  operand values
- ID_rX, ID_rY, ID_rO  in  REG_AW  source and destination register indices
- ID_alu_op  in  ALUOP_W  ALU op
- ID_reg_wen, ID_dmem_ren, ID_dmem_wen, ID_halt  in  1  control bits
- EX_valid  out  1  EX holds a real instruction
- EX_pc, EX_opA, EX_opB  out  DATA_W  registered copies
- EX_rX, EX_rY, EX_rO  out  REG_AW  registered indices
- EX_alu_op  out  ALUOP_W  registered ALU op
- EX_reg_wen, EX_dmem_ren, EX_dmem_wen, EX_halt  out  1  registered controls, all forced 0 when !EX_valid
- halted  out  1  sticky: a halt has entered EX
- bubble_count  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (rst_n=0, async): every output is 0; FSM=RUN.
- All updates occur on the rising clk edge; latency ID→EX is 1 cycle.
- Per-cycle action, in priority order:
  1. flush_id2ex → load NOP
  2. freeze_id2ex → hold all EX_* regs
  3. bubble_id2ex → load NOP
  4. otherwise → load ID_* fields, with EX_valid=ID_valid
- Flush beats freeze: a squash is never lost under a memory stall.
- Freeze beats bubble: the stalled load stays in EX, so the hazard persists and is re-evaluated next cycle.
- NOP definition: EX_valid, EX_reg_wen, EX_dmem_ren, EX_dmem_wen, EX_halt are all 0. Data and index fields are don't-care and are zeroed for determinism.
- Control outputs are 0 whenever EX_valid=0. This guarantees a bubble never asserts EX_dmem_ren, so the hazard unit cannot stall twice on the same load.
- Loading an ID_valid=0 instruction zeroes its controls the same way.
- FSM:
  - RUN → HALTED when a valid instruction with ID_halt=1 is actually loaded (case 4 only). halted rises the cycle EX_halt rises.
  - HALTED is sticky until reset. Every non-freeze cycle loads a NOP; freeze still holds; flush still loads a NOP.
- bubble_count:
  - Increments by 1 only in a cycle where case 3 is applied.
  - Saturates at 2^CNT_W−1.
  - cnt_clr sets it to 0 and takes priority over a simultaneous increment.
  - It does not change while HALTED (case 3 no longer applies there).
- Reset asserted mid-stall clears everything immediately, regardless of clk.

Decomposition:
- Shared package (pipe_pkg): the ID→EX bundle field widths (DATA_W, REG_AW, ALUOP_W) and the NOP control encoding. The hazard, forwarding and EX blocks share these.
- One sub-module: sat_counter (parameterised width, inc, clr, saturation) for bubble_count, reusable for other perf counters.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with arbitrary inputs → all outputs 0 asynchronously; bubble_count=0.
- Pass-through: ID_valid=1, ID_pc=0x0040, ID_rO=3, ID_dmem_ren=1, no controls → next edge EX_pc=0x0040, EX_rO=3, EX_dmem_ren=1, EX_valid=1.
- Load-use bubble: with a load in EX, assert bubble_id2ex=1 for 1 cycle → EX_valid=0, EX_dmem_ren=0, bubble_count=1. The held ID instruction loads on the following cycle.
- Priority:
  - flush+freeze+bubble all 1 → NOP loaded, count unchanged.
  - freeze+bubble → EX regs unchanged, count unchanged.
- Halt: valid instruction with ID_halt=1 → EX_halt=1 and halted=1 after 1 edge. Subsequent valid ID inputs yield EX_valid=0; halted stays 1 until rst_n=0.
- Counter edge: CNT_W=4, apply 17 bubbles → bubble_count=15. Then cnt_clr=1 together with bubble → bubble_count=0.

Source files
------------

// File: rtl/id2ex_pipe_pkg.sv
// Shared ID->EX bundle definitions: field widths, NOP control encoding and
// the per-cycle action priority used by the pipeline register.
package id2ex_pipe_pkg;

    localparam int PIPE_DATA_W  = 16;
    localparam int PIPE_REG_AW  = 3;
    localparam int PIPE_ALUOP_W = 5;
    localparam int PIPE_CNT_W   = 16;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } pipe_state_e;

    // What the ID->EX register does on a given edge.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,  // capture the ID bundle
        ACT_HOLD   = 2'd1,  // keep the EX bundle (freeze)
        ACT_NOP    = 2'd2,  // squash: flush, or any non-freeze cycle once halted
        ACT_BUBBLE = 2'd3   // load-use bubble, counted
    } pipe_act_e;

    typedef struct packed {
        logic reg_wen;
        logic dmem_ren;
        logic dmem_wen;
        logic halt;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NOP = '0;

    // Flush beats freeze so a squash survives a memory stall; freeze beats
    // bubble so the stalled load stays visible to the hazard unit.
    function automatic pipe_act_e pick_action(input logic flush,
                                              input logic freeze,
                                              input logic bubble,
                                              input logic halted);
        if (flush)       return ACT_NOP;
        else if (freeze) return ACT_HOLD;
        else if (halted) return ACT_NOP;
        else if (bubble) return ACT_BUBBLE;
        else             return ACT_LOAD;
    endfunction

    // An invalid slot must never carry live controls into EX.
    function automatic pipe_ctrl_t gate_ctrl(input logic valid, input pipe_ctrl_t c);
        return valid ? c : CTRL_NOP;
    endfunction

endpackage

// File: rtl/id2ex_pipe_if.sv
// ID->EX bundle plus stall controls and status outputs of the pipeline register.
interface id2ex_pipe_if #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 3,
    parameter int ALUOP_W = 5,
    parameter int CNT_W   = 16
);
    logic               bubble_id2ex;
    logic               freeze_id2ex;
    logic               flush_id2ex;
    logic               cnt_clr;

    logic               ID_valid;
    logic [DATA_W-1:0]  ID_pc;
    logic [DATA_W-1:0]  ID_opA;
    logic [DATA_W-1:0]  ID_opB;
    logic [REG_AW-1:0]  ID_rX;
    logic [REG_AW-1:0]  ID_rY;
    logic [REG_AW-1:0]  ID_rO;
    logic [ALUOP_W-1:0] ID_alu_op;
    logic               ID_reg_wen;
    logic               ID_dmem_ren;
    logic               ID_dmem_wen;
    logic               ID_halt;

    logic               EX_valid;
    logic [DATA_W-1:0]  EX_pc;
    logic [DATA_W-1:0]  EX_opA;
    logic [DATA_W-1:0]  EX_opB;
    logic [REG_AW-1:0]  EX_rX;
    logic [REG_AW-1:0]  EX_rY;
    logic [REG_AW-1:0]  EX_rO;
    logic [ALUOP_W-1:0] EX_alu_op;
    logic               EX_reg_wen;
    logic               EX_dmem_ren;
    logic               EX_dmem_wen;
    logic               EX_halt;

    logic               halted;
    logic [CNT_W-1:0]   bubble_count;

    // Upstream side: ID stage and hazard/stall logic.
    modport master (
        output bubble_id2ex, freeze_id2ex, flush_id2ex, cnt_clr,
        output ID_valid, ID_pc, ID_opA, ID_opB, ID_rX, ID_rY, ID_rO, ID_alu_op,
        output ID_reg_wen, ID_dmem_ren, ID_dmem_wen, ID_halt,
        input  EX_valid, EX_pc, EX_opA, EX_opB, EX_rX, EX_rY, EX_rO, EX_alu_op,
        input  EX_reg_wen, EX_dmem_ren, EX_dmem_wen, EX_halt,
        input  halted, bubble_count
    );

    // Pipeline register side.
    modport slave (
        input  bubble_id2ex, freeze_id2ex, flush_id2ex, cnt_clr,
        input  ID_valid, ID_pc, ID_opA, ID_opB, ID_rX, ID_rY, ID_rO, ID_alu_op,
        input  ID_reg_wen, ID_dmem_ren, ID_dmem_wen, ID_halt,
        output EX_valid, EX_pc, EX_opA, EX_opB, EX_rX, EX_rY, EX_rO, EX_alu_op,
        output EX_reg_wen, EX_dmem_ren, EX_dmem_wen, EX_halt,
        output halted, bubble_count
    );

endinterface

// File: rtl/id2ex_pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; generic perf-counter building block.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over increment; increment stops at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (inc_i && (count_q != {W{1'b1}}))
            count_d = count_q + W'(1);
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/id2ex_pipe.sv
// ID->EX pipeline register: flush/freeze/bubble handling, sticky halt and
// bubble performance counter. EX controls are kept zero whenever EX_valid=0
// so a bubble can never re-trigger the load-use hazard.
module id2ex_pipe
    import id2ex_pipe_pkg::*;
#(
    parameter int DATA_W  = PIPE_DATA_W,
    parameter int REG_AW  = PIPE_REG_AW,
    parameter int ALUOP_W = PIPE_ALUOP_W,
    parameter int CNT_W   = PIPE_CNT_W
) (
    input logic         clk,
    input logic         rst_n,
    id2ex_pipe_if.slave bus
);

    pipe_state_e        state_q;
    logic               valid_q;
    logic [DATA_W-1:0]  pc_q;
    logic [DATA_W-1:0]  opa_q;
    logic [DATA_W-1:0]  opb_q;
    logic [REG_AW-1:0]  rx_q;
    logic [REG_AW-1:0]  ry_q;
    logic [REG_AW-1:0]  ro_q;
    logic [ALUOP_W-1:0] alu_op_q;
    pipe_ctrl_t         ctrl_q;

    pipe_act_e          act_d;
    pipe_ctrl_t         id_ctrl;
    logic [CNT_W-1:0]   bubble_count;

    assign id_ctrl = '{reg_wen:  bus.ID_reg_wen,
                       dmem_ren: bus.ID_dmem_ren,
                       dmem_wen: bus.ID_dmem_wen,
                       halt:     bus.ID_halt};

    // Resolve the stall controls into one action for this edge.
    always_comb begin
        act_d = pick_action(bus.flush_id2ex, bus.freeze_id2ex, bus.bubble_id2ex,
                            state_q == ST_HALTED);
    end

    // Run/halted FSM together with the EX bundle registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b0;
            pc_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rx_q     <= '0;
            ry_q     <= '0;
            ro_q     <= '0;
            alu_op_q <= '0;
            ctrl_q   <= CTRL_NOP;
        end else begin
            case (act_d)
                ACT_LOAD: begin
                    valid_q  <= bus.ID_valid;
                    pc_q     <= bus.ID_pc;
                    opa_q    <= bus.ID_opA;
                    opb_q    <= bus.ID_opB;
                    rx_q     <= bus.ID_rX;
                    ry_q     <= bus.ID_rY;
                    ro_q     <= bus.ID_rO;
                    alu_op_q <= bus.ID_alu_op;
                    ctrl_q   <= gate_ctrl(bus.ID_valid, id_ctrl);
                    // Only a real halt instruction actually entering EX stops the pipe.
                    if (bus.ID_valid && bus.ID_halt)
                        state_q <= ST_HALTED;
                end
                ACT_HOLD: begin
                end
                default: begin
                    // Data fields are don't-care in a NOP; zero them for determinism.
                    valid_q  <= 1'b0;
                    pc_q     <= '0;
                    opa_q    <= '0;
                    opb_q    <= '0;
                    rx_q     <= '0;
                    ry_q     <= '0;
                    ro_q     <= '0;
                    alu_op_q <= '0;
                    ctrl_q   <= CTRL_NOP;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_bubble_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (bus.cnt_clr),
        .inc_i   (act_d == ACT_BUBBLE),
        .count_o (bubble_count)
    );

    assign bus.EX_valid     = valid_q;
    assign bus.EX_pc        = pc_q;
    assign bus.EX_opA       = opa_q;
    assign bus.EX_opB       = opb_q;
    assign bus.EX_rX        = rx_q;
    assign bus.EX_rY        = ry_q;
    assign bus.EX_rO        = ro_q;
    assign bus.EX_alu_op    = alu_op_q;
    assign bus.EX_reg_wen   = ctrl_q.reg_wen;
    assign bus.EX_dmem_ren  = ctrl_q.dmem_ren;
    assign bus.EX_dmem_wen  = ctrl_q.dmem_wen;
    assign bus.EX_halt      = ctrl_q.halt;
    assign bus.halted       = (state_q == ST_HALTED);
    assign bus.bubble_count = bubble_count;

endmodule

// File: tb/tb_id2ex_pipe.sv
// Self-checking bench for id2ex_pipe: directed table, hand-written corner
// sequences and randomized stimulus against a behavioural model.
module tb_id2ex_pipe;

    localparam int DW   = 16;
    localparam int AW   = 3;
    localparam int OW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;

    id2ex_pipe_if #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW), .CNT_W(CW)) bus ();

    id2ex_pipe #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          flush, freeze, bubble, clr;
        logic          valid;
        logic [DW-1:0] pc, opa, opb;
        logic [AW-1:0] rx, ry, ro;
        logic [OW-1:0] alu;
        logic          wen, ren, mwen, halt;
    } in_t;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc, opa, opb;
        logic [AW-1:0] rx, ry, ro;
        logic [OW-1:0] alu;
        logic          wen, ren, mwen, halt;
    } ex_t;

    typedef struct {
        logic          flush, freeze, bubble, clr, valid;
        logic [DW-1:0] pc;
        logic [AW-1:0] ro;
        logic          ren;
        logic          e_valid;
        logic [DW-1:0] e_pc;
        logic [AW-1:0] e_ro;
        logic          e_ren;
        int            e_cnt;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    ex_t m_ex;
    bit  m_halted;
    int  m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour of one clock edge, from the action priority rules.
    task automatic model_step(input in_t v);
        if (v.flush) begin
            m_ex = '0;
        end else if (v.freeze) begin
            m_ex = m_ex;
        end else if (m_halted) begin
            m_ex = '0;
        end else if (v.bubble) begin
            m_ex  = '0;
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end else begin
            m_ex.valid = v.valid;
            m_ex.pc    = v.pc;
            m_ex.opa   = v.opa;
            m_ex.opb   = v.opb;
            m_ex.rx    = v.rx;
            m_ex.ry    = v.ry;
            m_ex.ro    = v.ro;
            m_ex.alu   = v.alu;
            m_ex.wen   = v.valid & v.wen;
            m_ex.ren   = v.valid & v.ren;
            m_ex.mwen  = v.valid & v.mwen;
            m_ex.halt  = v.valid & v.halt;
            if (v.valid && v.halt) m_halted = 1'b1;
        end
        if (v.clr) m_cnt = 0;
    endtask

    task automatic model_reset();
        m_ex     = '0;
        m_halted = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic put(input in_t v);
        bus.flush_id2ex  = v.flush;
        bus.freeze_id2ex = v.freeze;
        bus.bubble_id2ex = v.bubble;
        bus.cnt_clr      = v.clr;
        bus.ID_valid     = v.valid;
        bus.ID_pc        = v.pc;
        bus.ID_opA       = v.opa;
        bus.ID_opB       = v.opb;
        bus.ID_rX        = v.rx;
        bus.ID_rY        = v.ry;
        bus.ID_rO        = v.ro;
        bus.ID_alu_op    = v.alu;
        bus.ID_reg_wen   = v.wen;
        bus.ID_dmem_ren  = v.ren;
        bus.ID_dmem_wen  = v.mwen;
        bus.ID_halt      = v.halt;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".EX_valid"},     32'(bus.EX_valid),     32'(m_ex.valid));
        chk({tag, ".EX_pc"},        32'(bus.EX_pc),        32'(m_ex.pc));
        chk({tag, ".EX_opA"},       32'(bus.EX_opA),       32'(m_ex.opa));
        chk({tag, ".EX_opB"},       32'(bus.EX_opB),       32'(m_ex.opb));
        chk({tag, ".EX_rX"},        32'(bus.EX_rX),        32'(m_ex.rx));
        chk({tag, ".EX_rY"},        32'(bus.EX_rY),        32'(m_ex.ry));
        chk({tag, ".EX_rO"},        32'(bus.EX_rO),        32'(m_ex.ro));
        chk({tag, ".EX_alu_op"},    32'(bus.EX_alu_op),    32'(m_ex.alu));
        chk({tag, ".EX_reg_wen"},   32'(bus.EX_reg_wen),   32'(m_ex.wen));
        chk({tag, ".EX_dmem_ren"},  32'(bus.EX_dmem_ren),  32'(m_ex.ren));
        chk({tag, ".EX_dmem_wen"},  32'(bus.EX_dmem_wen),  32'(m_ex.mwen));
        chk({tag, ".EX_halt"},      32'(bus.EX_halt),      32'(m_ex.halt));
        chk({tag, ".halted"},       32'(bus.halted),       32'(m_halted));
        chk({tag, ".bubble_count"}, 32'(bus.bubble_count), 32'(m_cnt));
    endtask

    // Apply inputs, advance one edge, sample 1 time unit after it.
    task automatic step(input in_t v, input string tag);
        put(v);
        model_step(v);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    // Reset asserted between edges must clear everything without a clock.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        #2;
        rst_n = 1'b1;
    endtask

    function automatic in_t base_in(input logic [DW-1:0] pc);
        in_t v;
        v       = '0;
        v.valid = 1'b1;
        v.pc    = pc;
        v.opa   = 16'h1234;
        v.opb   = 16'h5678;
        v.rx    = 3'd1;
        v.ry    = 3'd2;
        v.alu   = 5'h0A;
        v.wen   = 1'b1;
        return v;
    endfunction

    function automatic in_t rand_in();
        in_t v;
        v.flush  = ($urandom_range(0, 7) == 0);
        v.freeze = ($urandom_range(0, 4) == 0);
        v.bubble = ($urandom_range(0, 3) == 0);
        v.clr    = ($urandom_range(0, 19) == 0);
        v.valid  = ($urandom_range(0, 3) != 0);
        v.pc     = DW'($urandom);
        v.opa    = DW'($urandom);
        v.opb    = DW'($urandom);
        v.rx     = AW'($urandom);
        v.ry     = AW'($urandom);
        v.ro     = AW'($urandom);
        v.alu    = OW'($urandom);
        v.wen    = 1'($urandom);
        v.ren    = 1'($urandom);
        v.mwen   = 1'($urandom);
        v.halt   = ($urandom_range(0, 59) == 0);
        return v;
    endfunction

    vec_t vecs[10];

    initial begin
        in_t v;

        vecs[0] = '{0,0,0,0,1, 16'h0040, 3'd3, 1, 1, 16'h0040, 3'd3, 1, 0};
        vecs[1] = '{0,0,1,0,1, 16'h0044, 3'd4, 0, 0, 16'h0000, 3'd0, 0, 1};
        vecs[2] = '{0,0,0,0,1, 16'h0044, 3'd4, 0, 1, 16'h0044, 3'd4, 0, 1};
        vecs[3] = '{0,1,1,0,1, 16'h0048, 3'd6, 1, 1, 16'h0044, 3'd4, 0, 1};
        vecs[4] = '{1,1,1,0,1, 16'h0048, 3'd6, 1, 0, 16'h0000, 3'd0, 0, 1};
        vecs[5] = '{0,0,0,0,0, 16'h004C, 3'd5, 1, 0, 16'h004C, 3'd5, 0, 1};
        vecs[6] = '{0,0,0,0,1, 16'h0050, 3'd2, 1, 1, 16'h0050, 3'd2, 1, 1};
        vecs[7] = '{0,0,1,1,1, 16'h0054, 3'd7, 1, 0, 16'h0000, 3'd0, 0, 0};
        vecs[8] = '{0,0,1,0,1, 16'h0058, 3'd7, 1, 0, 16'h0000, 3'd0, 0, 1};
        vecs[9] = '{0,1,0,0,1, 16'h005C, 3'd1, 1, 0, 16'h0000, 3'd0, 0, 1};

        rst_n = 1'b0;
        put(base_in(16'h00AA));
        model_reset();
        #3;
        compare_all("por");
        #3;
        rst_n = 1'b1;

        // Directed table.
        foreach (vecs[i]) begin
            v        = base_in(vecs[i].pc);
            v.flush  = vecs[i].flush;
            v.freeze = vecs[i].freeze;
            v.bubble = vecs[i].bubble;
            v.clr    = vecs[i].clr;
            v.valid  = vecs[i].valid;
            v.ro     = vecs[i].ro;
            v.ren    = vecs[i].ren;
            step(v, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.valid", i), 32'(bus.EX_valid),    32'(vecs[i].e_valid));
            chk($sformatf("vec%0d.pc", i),    32'(bus.EX_pc),       32'(vecs[i].e_pc));
            chk($sformatf("vec%0d.rO", i),    32'(bus.EX_rO),       32'(vecs[i].e_ro));
            chk($sformatf("vec%0d.ren", i),   32'(bus.EX_dmem_ren), 32'(vecs[i].e_ren));
            chk($sformatf("vec%0d.cnt", i),   32'(bus.bubble_count), 32'(vecs[i].e_cnt));
        end

        // Mid-stall asynchronous reset with live inputs.
        v        = base_in(16'h0060);
        v.freeze = 1'b1;
        v.bubble = 1'b1;
        put(v);
        do_reset("rst_midstall");

        // Halt: enters EX, then sticky; bubbles no longer counted.
        v      = base_in(16'h0080);
        v.halt = 1'b1;
        step(v, "halt_in");
        chk("halt.EX_halt",  32'(bus.EX_halt),  32'd1);
        chk("halt.halted",   32'(bus.halted),   32'd1);
        chk("halt.EX_valid", 32'(bus.EX_valid), 32'd1);
        v     = base_in(16'h0084);
        v.ren = 1'b1;
        step(v, "halt_next");
        chk("halt_next.EX_valid", 32'(bus.EX_valid),    32'd0);
        chk("halt_next.ren",      32'(bus.EX_dmem_ren), 32'd0);
        chk("halt_next.halted",   32'(bus.halted),      32'd1);
        v        = base_in(16'h0088);
        v.bubble = 1'b1;
        step(v, "halt_bubble");
        chk("halt_bubble.cnt", 32'(bus.bubble_count), 32'd0);
        v        = base_in(16'h008C);
        v.freeze = 1'b1;
        step(v, "halt_freeze");
        chk("halt_freeze.halted", 32'(bus.halted), 32'd1);
        do_reset("halt_rst");
        chk("halt_rst.halted", 32'(bus.halted), 32'd0);

        // Counter saturation and clear-over-increment.
        for (int k = 1; k <= 17; k++) begin
            v        = base_in(DW'(16'h0100 + k));
            v.bubble = 1'b1;
            step(v, $sformatf("sat%0d", k));
            if (k == 1)  chk("sat.first", 32'(bus.bubble_count), 32'd1);
            if (k == 15) chk("sat.top",   32'(bus.bubble_count), 32'd15);
            if (k == 17) chk("sat.hold",  32'(bus.bubble_count), 32'd15);
        end
        v        = base_in(16'h0200);
        v.bubble = 1'b1;
        v.clr    = 1'b1;
        step(v, "sat_clr");
        chk("sat.clr", 32'(bus.bubble_count), 32'd0);

        // Randomized against the model, with periodic async resets.
        for (int r = 0; r < 4; r++) begin
            do_reset($sformatf("rnd_rst%0d", r));
            for (int c = 0; c < 100; c++)
                step(rand_in(), $sformatf("rnd%0d_%0d", r, c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
